// File: rtl/grey_pkg.sv
// Shared definitions for the Grey decode tracker and its step classifier.
// State encodings and width helpers used by every block in this slice.
package grey_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Bit index counter width; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/grey_step_classify.sv
// Combinational step classifier: compares a new binary sample with the
// previous one and reports first/up/down/illegal-step flags.
module grey_step_classify
   import grey_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] bin_next,
   input  logic [N-1:0] prev,
   input  logic         has_prev,
   output logic         first,
   output logic         dir_up,
   output logic         dir_down,
   output logic         step_err
);

   logic [N-1:0] prev_inc;
   logic [N-1:0] prev_dec;

   // N-bit modulo neighbours, so wrap-around counts as a unit step.
   assign prev_inc = prev + N'(1);
   assign prev_dec = prev - N'(1);

   always_comb begin
      first    = 1'b0;
      dir_up   = 1'b0;
      dir_down = 1'b0;
      step_err = 1'b0;
      if (!has_prev)
         first = 1'b1;
      else if (bin_next == prev_inc)
         dir_up = 1'b1;
      else if (bin_next == prev_dec)
         dir_down = 1'b1;
      else if (bin_next != prev)
         step_err = 1'b1;
   end

endmodule

// File: rtl/grey_to_bin_tracker.sv
// Accepts Grey words over valid/ready, decodes them MSB first one bit per
// clock, and presents the binary value with its step classification.
module grey_to_bin_tracker
   import grey_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] grey,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] bin,
   output logic         first,
   output logic         dir_up,
   output logic         dir_down,
   output logic         step_err,
   output logic [1:0]   dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; valid holds its data stable until that edge.

   localparam int               IDX_W   = idx_w(N);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

   state_t           state;
   logic [N-1:0]     g_q;
   logic [N-1:0]     prev;
   logic             has_prev;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_up;
   logic             hi_bit;
   logic [N-1:0]     bin_next;
   logic             c_first;
   logic             c_up;
   logic             c_down;
   logic             c_err;

   assign dbg_state = state;
   assign idx_up    = idx + IDX_W'(1);

   // The MSB has no higher neighbour; every other bit XORs with the bit above.
   always_comb begin
      hi_bit        = (idx == IDX_TOP) ? 1'b0 : bin[idx_up];
      bin_next      = bin;
      bin_next[idx] = hi_bit ^ g_q[idx];
   end

   grey_step_classify #(.N(N)) u_classify (
      .bin_next (bin_next),
      .prev     (prev),
      .has_prev (has_prev),
      .first    (c_first),
      .dir_up   (c_up),
      .dir_down (c_down),
      .step_err (c_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         bin       <= '0;
         first     <= 1'b0;
         dir_up    <= 1'b0;
         dir_down  <= 1'b0;
         step_err  <= 1'b0;
         has_prev  <= 1'b0;
         prev      <= '0;
         idx       <= IDX_TOP;
         g_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  g_q      <= grey;
                  idx      <= IDX_TOP;
                  in_ready <= 1'b0;
                  state    <= DECODE;
               end
            end
            DECODE: begin
               bin <= bin_next;
               if (idx == '0) begin
                  first     <= c_first;
                  dir_up    <= c_up;
                  dir_down  <= c_down;
                  step_err  <= c_err;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx - IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  prev      <= bin;
                  has_prev  <= 1'b1;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
